// File: rtl/mem_pkg.sv
// Shared types and defaults for the mem_access load/store unit.
// Holds the FSM state type plus an illegal-operation decode used at accept time.
package mem_pkg;

  localparam int unsigned DefaultN       = 64;
  localparam int unsigned DefaultTimeout = 16;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  // Conflicting flags, or any memory access that is not 8-byte aligned.
  function automatic logic is_bad_op(input logic rd, input logic wr, input logic [2:0] lo);
    return (rd && wr) || ((rd || wr) && (lo != 3'b000));
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Execute-stage, data-memory and writeback signals of the mem_access unit.
// The slave modport is the unit itself; master is the surrounding pipeline and memory.
interface mem_access_if
  import mem_pkg::*;
#(
  parameter int unsigned N = DefaultN
);

  logic         ex_valid;
  logic         ex_ready;
  logic [N-1:0] ex_addr;
  logic [N-1:0] ex_wdata;
  logic         ex_memread;
  logic         ex_memwrite;

  logic         dm_req;
  logic         dm_we;
  logic [N-1:0] dm_addr;
  logic [N-1:0] dm_wdata;
  logic         dm_gnt;
  logic         dm_rvalid;
  logic [N-1:0] dm_rdata;

  logic         wb_valid;
  logic         wb_err;
  logic [N-1:0] wb_data;
  logic         wb_ready;

  modport slave (
    input  ex_valid, ex_addr, ex_wdata, ex_memread, ex_memwrite,
    output ex_ready,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    output wb_valid, wb_err, wb_data,
    input  wb_ready
  );

  modport master (
    output ex_valid, ex_addr, ex_wdata, ex_memread, ex_memwrite,
    input  ex_ready,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    input  wb_valid, wb_err, wb_data,
    output wb_ready
  );

endinterface

// File: rtl/mem_timer.sv
// Cycle counter bounding the time an access may spend waiting on memory.
// expired is high in the cycle whose edge brings the count to TIMEOUT (or beyond).
module mem_timer #(
  parameter  int unsigned TIMEOUT = 16,
  localparam int unsigned W       = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] Last  = W'(TIMEOUT - 1);
  localparam logic [W-1:0] Limit = W'(TIMEOUT);

  logic [W-1:0] cnt_q;

  // Saturate so a long wait can never wrap back below the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != Limit)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = enable && (cnt_q >= Last);

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one aligned load/store at a time to data memory,
// passes ALU results through, flags illegal or timed-out accesses to writeback.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned N       = DefaultN,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input logic         clk,
  input logic         reset,
  mem_access_if.slave bus
);

  state_e       state_q, state_d;
  logic [N-1:0] addr_q, wdata_q;
  logic         rd_q, wr_q;
  logic [N-1:0] wb_data_q, wb_data_d;
  logic         wb_err_q, wb_err_d;
  logic         accept;
  logic         timer_en;
  logic         expired;

  assign accept   = bus.ex_valid && (state_q == StIdle);
  assign timer_en = (state_q == StReq) || (state_q == StWait);

  mem_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (timer_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.ex_addr;
      wdata_q <= bus.ex_wdata;
      rd_q    <= bus.ex_memread;
      wr_q    <= bus.ex_memwrite;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_data_q <= wb_data_d;
      wb_err_q  <= wb_err_d;
    end
  end

  // Completion (gnt/rvalid) is checked before expiry so it wins in the final cycle.
  always_comb begin
    state_d   = state_q;
    wb_data_d = wb_data_q;
    wb_err_d  = wb_err_q;
    case (state_q)
      StIdle: begin
        if (bus.ex_valid) begin
          if (is_bad_op(bus.ex_memread, bus.ex_memwrite, bus.ex_addr[2:0])) begin
            state_d   = StDone;
            wb_data_d = '0;
            wb_err_d  = 1'b1;
          end else if (bus.ex_memread || bus.ex_memwrite) begin
            state_d = StReq;
          end else begin
            state_d   = StDone;
            wb_data_d = bus.ex_addr;
            wb_err_d  = 1'b0;
          end
        end
      end
      StReq: begin
        if (bus.dm_gnt) begin
          if (wr_q) begin
            state_d   = StDone;
            wb_data_d = '0;
            wb_err_d  = 1'b0;
          end else begin
            state_d = StWait;
          end
        end else if (expired) begin
          state_d   = StDone;
          wb_data_d = '0;
          wb_err_d  = 1'b1;
        end
      end
      StWait: begin
        if (bus.dm_rvalid) begin
          state_d   = StDone;
          wb_data_d = bus.dm_rdata;
          wb_err_d  = 1'b0;
        end else if (expired) begin
          state_d   = StDone;
          wb_data_d = '0;
          wb_err_d  = 1'b1;
        end
      end
      StDone: begin
        if (bus.wb_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.ex_ready = (state_q == StIdle);
  assign bus.dm_req   = (state_q == StReq);
  assign bus.dm_we    = (state_q == StReq) && wr_q;
  assign bus.dm_addr  = addr_q;
  assign bus.dm_wdata = wdata_q;
  assign bus.wb_valid = (state_q == StDone);
  assign bus.wb_err   = wb_err_q;
  assign bus.wb_data  = wb_data_q;

  a_req_stable: assert property (@(posedge clk) disable iff (!reset)
    bus.dm_req && !bus.dm_gnt && !expired |=>
      bus.dm_req && $stable(bus.dm_addr) && $stable(bus.dm_wdata) && $stable(bus.dm_we));

  a_wb_stable: assert property (@(posedge clk) disable iff (!reset)
    bus.wb_valid && !bus.wb_ready |=>
      bus.wb_valid && $stable(bus.wb_data) && $stable(bus.wb_err));

endmodule
